// File: rtl/rriscv_pkg.sv
// Shared core constants: datapath width and architectural register count.
package rriscv_pkg;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  typedef logic [$clog2(NUM_REGS)-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_rport.sv
// One combinational read port: register mux, write-to-read bypass and busy masking.
module regfile_rport #(
  parameter int XLEN     = rriscv_pkg::XLEN,
  parameter int NUM_REGS = rriscv_pkg::NUM_REGS,
  parameter bit BYPASS   = 1'b1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS*XLEN-1:0] regs_i,
  input  logic [NUM_REGS-1:0]      busy_i,
  input  logic [AW-1:0]            raddr_i,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic [XLEN-1:0]          wdata_i,
  output logic [XLEN-1:0]          rdata_o,
  output logic                     busy_o
);
  logic hit;

  // wr_en_i already excludes halted cycles and address 0, so no bypass then.
  always_comb begin
    hit     = BYPASS && wr_en_i && (waddr_i == raddr_i) && (raddr_i != '0);
    rdata_o = '0;
    busy_o  = 1'b0;
    if (hit) begin
      rdata_o = wdata_i;
    end else if (raddr_i != '0) begin
      rdata_o = regs_i[raddr_i*XLEN +: XLEN];
      busy_o  = busy_i[raddr_i];
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits and a sticky
// error flag for double reservations. Storage and scoreboard live here.
module regfile_sb #(
  parameter int XLEN       = rriscv_pkg::XLEN,
  parameter int NUM_REGS   = rriscv_pkg::NUM_REGS,
  parameter int NUM_RPORTS = 2,
  parameter bit BYPASS     = 1'b1,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       halt_i,
  input  logic                       we_i,
  input  logic [AW-1:0]              waddr_i,
  input  logic [XLEN-1:0]            wdata_i,
  input  logic                       rsv_i,
  input  logic [AW-1:0]              rsv_addr_i,
  input  logic                       flush_i,
  input  logic [NUM_RPORTS*AW-1:0]   raddr_i,
  output logic [NUM_RPORTS*XLEN-1:0] rdata_o,
  output logic [NUM_RPORTS-1:0]      busy_o,
  output logic                       err_o
);
  logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
  logic [NUM_REGS-1:0]           busy_q, busy_d;
  logic                          err_q, err_d;
  logic                          wr_eff, rsv_eff, flush_eff;

  assign wr_eff    = we_i && !halt_i && (waddr_i != '0);
  assign rsv_eff   = rsv_i && !halt_i && (rsv_addr_i != '0);
  assign flush_eff = flush_i && !halt_i;

  // Priority low to high: flush, write clear, reserve set.
  always_comb begin
    busy_d = busy_q;
    if (flush_eff) busy_d = '0;
    if (wr_eff) busy_d[waddr_i] = 1'b0;
    if (rsv_eff) busy_d[rsv_addr_i] = 1'b1;
    busy_d[0] = 1'b0;

    err_d = err_q;
    if (rsv_eff && busy_q[rsv_addr_i] && !(wr_eff && (waddr_i == rsv_addr_i)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      regs_q <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
      if (wr_eff) regs_q[waddr_i] <= wdata_i;
    end
  end

  assign err_o = err_q;

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    regfile_rport #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .BYPASS   (BYPASS),
      .AW       (AW)
    ) u_rport (
      .regs_i  (regs_q),
      .busy_i  (busy_q),
      .raddr_i (raddr_i[p*AW +: AW]),
      .wr_en_i (wr_eff),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o[p*XLEN +: XLEN]),
      .busy_o  (busy_o[p])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance
// share the same stimulus.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n, halt, we, rsv, flush;
  logic [4:0]  waddr, rsv_addr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  busy, busy_nb;
  logic        err, err_nb;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  regfile_sb #(.NUM_RPORTS(2), .BYPASS(1'b1)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .halt_i(halt), .we_i(we), .waddr_i(waddr),
    .wdata_i(wdata), .rsv_i(rsv), .rsv_addr_i(rsv_addr), .flush_i(flush),
    .raddr_i(raddr), .rdata_o(rdata), .busy_o(busy), .err_o(err)
  );

  regfile_sb #(.NUM_RPORTS(2), .BYPASS(1'b0)) u_dut_nb (
    .clk_i(clk), .rst_n_i(rst_n), .halt_i(halt), .we_i(we), .waddr_i(waddr),
    .wdata_i(wdata), .rsv_i(rsv), .rsv_addr_i(rsv_addr), .flush_i(flush),
    .raddr_i(raddr), .rdata_o(rdata_nb), .busy_o(busy_nb), .err_o(err_nb)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    halt = 1'b0; we = 1'b0; rsv = 1'b0; flush = 1'b0;
  endtask

  task automatic rd_at(input logic [4:0] a1, input logic [4:0] a0);
    raddr = {a1, a0};
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; idle(); waddr = '0; wdata = '0; rsv_addr = '0; raddr = '0;
    tick(); tick();
    rst_n = 1'b1;
    rd_at(5'd0, 5'd5);
    chk("reset_rdata", rdata, 64'h0);
    chk("reset_busy", {30'b0, busy}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);

    // x5 = DEADBEEF, visible next cycle
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick(); idle(); #1;
    chk("x5_read", rdata[31:0], 32'hDEADBEEF);
    chk("x5_read_nb", rdata_nb[31:0], 32'hDEADBEEF);

    // x0 write ignored, and no bypass for address 0
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    rd_at(5'd0, 5'd0);
    chk("x0_bypass", rdata[63:32], 32'h0);
    tick(); idle(); #1;
    chk("x0_read", rdata[63:32], 32'h0);

    // x7 = 11111111, then reserve x7
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
    tick(); idle();
    rsv = 1'b1; rsv_addr = 5'd7;
    tick(); idle();
    rd_at(5'd7, 5'd5);
    chk("x7_busy", {30'b0, busy}, 32'h2);
    chk("x7_busy_nb", {30'b0, busy_nb}, 32'h2);

    // same-cycle write x7 = A5A5A5A5 while port 1 reads x7
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    #1;
    chk("bypass_rdata", rdata[63:32], 32'hA5A5A5A5);
    chk("bypass_busy", {31'b0, busy[1]}, 32'h0);
    chk("nobyp_rdata_old", rdata_nb[63:32], 32'h11111111);
    chk("nobyp_busy_old", {31'b0, busy_nb[1]}, 32'h1);
    tick(); idle(); #1;
    chk("nobyp_rdata_new", rdata_nb[63:32], 32'hA5A5A5A5);
    chk("nobyp_busy_new", {31'b0, busy_nb[1]}, 32'h0);

    // scoreboard sequence on x3
    rsv = 1'b1; rsv_addr = 5'd3;
    tick(); idle();
    rd_at(5'd0, 5'd3);
    chk("x3_rsv_busy", {31'b0, busy[0]}, 32'h1);
    we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    tick(); idle(); #1;
    chk("x3_wr_busy", {31'b0, busy[0]}, 32'h0);
    chk("x3_wr_data", rdata[31:0], 32'h11);
    rsv = 1'b1; rsv_addr = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    tick(); idle(); #1;
    chk("x3_rsvwr_busy", {31'b0, busy[0]}, 32'h1);
    chk("x3_rsvwr_data", rdata[31:0], 32'h11);
    chk("x3_rsvwr_err", {31'b0, err}, 32'h0);
    // re-reserve while busy but cleared by a same-cycle write: no error
    rsv = 1'b1; rsv_addr = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    tick(); idle(); #1;
    chk("x3_rerv_wr_err", {31'b0, err}, 32'h0);
    chk("x3_rerv_wr_busy", {31'b0, busy[0]}, 32'h1);
    rsv = 1'b1; rsv_addr = 5'd3;
    tick(); idle(); #1;
    chk("x3_double_err", {31'b0, err}, 32'h1);
    chk("x3_double_err_nb", {31'b0, err_nb}, 32'h1);
    chk("x3_double_busy", {31'b0, busy[0]}, 32'h1);

    // halt blocks write, reserve and flush; no bypass while halted
    halt = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h99;
    rsv = 1'b1; rsv_addr = 5'd6; flush = 1'b1;
    rd_at(5'd6, 5'd3);
    chk("halt_no_bypass", rdata[31:0], 32'h11);
    tick(); #1;
    chk("halt_data", rdata[31:0], 32'h11);
    chk("halt_busy", {30'b0, busy}, 32'h1);
    idle();
    we = 1'b1; waddr = 5'd6; wdata = 32'h66;
    tick(); idle(); #1;
    chk("resume_write", rdata[63:32], 32'h66);

    // reserve x4 and x9, then flush
    rsv = 1'b1; rsv_addr = 5'd4;
    tick();
    rsv_addr = 5'd9;
    tick(); idle();
    rd_at(5'd9, 5'd4);
    chk("rsv_4_9_busy", {30'b0, busy}, 32'h3);
    flush = 1'b1;
    tick(); idle(); #1;
    chk("flush_busy", {30'b0, busy}, 32'h0);
    rd_at(5'd0, 5'd3);
    chk("flush_x3_busy", {31'b0, busy[0]}, 32'h0);
    chk("flush_x3_data", rdata[31:0], 32'h11);
    // reserve wins over a same-cycle flush
    flush = 1'b1; rsv = 1'b1; rsv_addr = 5'd4;
    tick(); idle();
    rd_at(5'd9, 5'd4);
    chk("flush_rsv_busy", {30'b0, busy}, 32'h1);

    // reset during a reservation, with halt high
    rsv = 1'b1; rsv_addr = 5'd9; halt = 1'b1; rst_n = 1'b0;
    tick(); idle(); rst_n = 1'b1;
    rd_at(5'd9, 5'd5);
    chk("rst_busy", {30'b0, busy}, 32'h0);
    chk("rst_data_x5", rdata[31:0], 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    rd_at(5'd7, 5'd3);
    chk("rst_data_x3_x7", rdata[31:0] | rdata[63:32] | rdata_nb[31:0], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default rriscv_pkg::XLEN (32): data width.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count, a power of two and at least 2; AW = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RPORTS, default 2: independent read ports, range 1..4.
REQ-004 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding.
REQ-005 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n_i  in  1  reset, synchronous, active-low.
REQ-007 halt_i  in  1  freezes all state updates while high.
REQ-008 we_i  in  1  writeback enable.
REQ-009 waddr_i  in  AW  writeback address.
REQ-010 wdata_i  in  XLEN  writeback data.
REQ-011 rsv_i  in  1  reserve request: marks a destination as pending.
REQ-012 rsv_addr_i  in  AW  reserve address.
REQ-013 flush_i  in  1  clears all pending marks.
REQ-014 raddr_i  in  NUM_RPORTS x AW  read addresses.
REQ-015 rdata_o  out  NUM_RPORTS x XLEN  read data.
REQ-016 busy_o  out  NUM_RPORTS  read operand is pending.
REQ-017 err_o  out  1  sticky protocol error.

Function
REQ-018 Reads SHALL be combinational, 0-cycle latency: rdata_o[p] = reg[raddr_i[p]].
REQ-019 Register 0 SHALL always read 0 and SHALL never be busy; writes and reserves to address 0 SHALL be ignored.
REQ-020 Writes SHALL take effect when we_i=1, halt_i=0 and waddr_i!=0; the new value is visible on the next cycle.
REQ-021 BYPASS=1 SHALL forward the write: when the write is effective and waddr_i==raddr_i[p]!=0, rdata_o[p]=wdata_i and busy_o[p]=0 in the same cycle.
REQ-022 BYPASS=0 SHALL give no forwarding; rdata_o shows the old value until the next cycle.
REQ-023 Scoreboard: the module SHALL keep one busy bit per register.
- An effective reserve (rsv_i=1, halt_i=0, rsv_addr_i!=0) sets the bit.
- An effective write clears the bit of waddr_i.
REQ-024 busy_o[p] SHALL be busy[raddr_i[p]], except when masked by a bypass hit per REQ-021.
REQ-025 Simultaneous reserve and write to the same address SHALL leave the bit set (reserve wins) and SHALL still update the data.
REQ-026 flush_i=1 with halt_i=0 SHALL clear all busy bits; data is unaffected.
- A reserve in the same cycle as flush still sets its bit (reserve wins over flush).
- A write in the same cycle as flush still commits.
REQ-027 A reserve to an already-busy register SHALL set err_o=1, unless a same-address effective write clears that register in the same cycle.
- The bit stays set.
- err_o holds until reset.
REQ-028 halt_i=1 SHALL block writes, reserves, flushes and err_o updates; reads and busy_o stay live, with no bypass.

Reset
REQ-029 With rst_n_i=0 at a rising edge, all registers, all busy bits and err_o SHALL go to 0; reset SHALL override halt_i and all other inputs.
REQ-030 Reset mid-operation SHALL discard all pending reservations; the first cycle after release shows every busy_o=0 and every rdata_o=0.

Structure
REQ-031 XLEN SHALL come from rriscv_pkg.
REQ-032 rriscv_pkg SHALL gain the constant NUM_REGS=32 and the typedef reg_addr_t (logic [$clog2(NUM_REGS)-1:0]).
REQ-033 The read path SHALL be one sub-module, regfile_rport, holding the mux, bypass and busy mask; it is instantiated NUM_RPORTS times in a generate loop.
- Data storage and scoreboard stay in the top module.

Verification
REQ-034 Reset, then write x5=0xDEADBEEF -> next cycle rdata_o[0]=0xDEADBEEF for raddr 5; write x0=0x1234 -> x0 still reads 0.
REQ-035 BYPASS=1: write x7=0xA5A5A5A5 while raddr_i[1]=7 -> same-cycle rdata_o[1]=0xA5A5A5A5 and busy_o[1]=0.
REQ-036 Repeat REQ-035 with BYPASS=0 -> rdata_o[1] shows the old value that cycle and the new value the next.
REQ-037 Scoreboard sequence:
- Reserve x3 -> busy_o=1 for raddr 3.
- Write x3=0x11 -> busy_o=0 on the next cycle.
- Reserve x3 plus write x3 in the same cycle -> busy stays 1, data=0x11, err_o=0.
- Reserve x3 again -> err_o=1.
REQ-038 halt_i=1 with we_i, rsv_i and flush_i all asserted -> no change in data or busy bits; deassert halt_i -> normal behaviour resumes.
REQ-039 Reserve x4 and x9, then flush_i -> all busy_o=0; assert rst_n_i=0 for one cycle during a reservation -> all data, busy and err_o are 0 after release.
